// File: rtl/fifo_wr_arb_4x60.sv
// rtl/fifo_wr_arb_4x60.sv - round-robin write arbiter for a 512xDW FIFO with a 2-entry output skid buffer
module fifo_wr_arb_4x60 #(
    parameter int DW   = 60,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              fifo_we,
    output logic [DW-1:0]     fifo_din,
    output logic              fifo_re,
    input  logic [DW-1:0]     fifo_dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              fifo_clr,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    input  logic              out_ready,
    output logic [9:0]        level,
    output logic [1:0]        last_gnt
);

    typedef enum logic [1:0] {E0, E1, E2} buf_state_e;

    buf_state_e  state_q;
    logic        pend_q;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  last_gnt_q, last_gnt_d;
    logic [9:0]  level_q, level_d;
    logic [DW-1:0] head_q, tail_q;

    logic        gnt_any;
    logic [1:0]  gnt_idx;
    logic        pop;
    logic [1:0]  entries;
    logic [2:0]  inflight;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[ptr_q + 2'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && !clr && !fifo_full && gnt_any) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    assign fifo_we   = |req_ready;
    assign fifo_din  = req_data[gnt_idx*DW +: DW];
    assign fifo_clr  = clr;

    assign out_valid = (state_q != E0);
    assign out_data  = head_q;
    assign pop       = out_valid & out_ready;
    assign entries   = (state_q == E2) ? 2'd2 : (state_q == E1) ? 2'd1 : 2'd0;
    assign inflight  = {1'b0, entries} + {2'b00, pend_q};
    // A read is issued only if its word is guaranteed a slot when it lands.
    assign fifo_re   = !rst && !clr && !fifo_empty && (inflight < (3'd2 + {2'b00, pop}));

    assign level     = level_q;
    assign last_gnt  = last_gnt_q;

    always_comb begin
        ptr_d      = ptr_q;
        last_gnt_d = last_gnt_q;
        if (fifo_we) begin
            ptr_d      = gnt_idx + 2'd1;
            last_gnt_d = gnt_idx;
        end
    end

    always_comb begin
        level_d = level_q;
        if (fifo_we && !pop && level_q != 10'h3ff) begin
            level_d = level_q + 10'd1;
        end else if (!fifo_we && pop && level_q != 10'd0) begin
            level_d = level_q - 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= E0;
            pend_q     <= 1'b0;
            ptr_q      <= 2'd0;
            last_gnt_q <= 2'd0;
            level_q    <= 10'd0;
        end else if (clr) begin
            state_q    <= E0;
            pend_q     <= 1'b0;
            ptr_q      <= 2'd0;
            last_gnt_q <= 2'd0;
            level_q    <= 10'd0;
        end else begin
            pend_q     <= fifo_re;
            ptr_q      <= ptr_d;
            last_gnt_q <= last_gnt_d;
            level_q    <= level_d;
            case (state_q)
                E0: if (pend_q) state_q <= E1;
                E1: begin
                    if (pend_q && !pop)      state_q <= E2;
                    else if (!pend_q && pop) state_q <= E0;
                end
                E2: if (pop && !pend_q) state_q <= E1;
                default: state_q <= E0;
            endcase
        end
    end

    // Payload registers need no reset; state_q alone decides what is valid.
    always_ff @(posedge clk) begin
        case (state_q)
            E0: if (pend_q) head_q <= fifo_dout;
            E1: begin
                if (pend_q && pop) head_q <= fifo_dout;
                else if (pend_q)   tail_q <= fifo_dout;
            end
            E2: begin
                if (pop) begin
                    head_q <= tail_q;
                    if (pend_q) tail_q <= fifo_dout;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arb_4x60.sv
// tb/tb_fifo_wr_arb_4x60.sv - scoreboard bench for fifo_wr_arb_4x60 with a behavioural 512-deep FIFO
module tb_fifo_wr_arb_4x60;
    localparam int DW    = 60;
    localparam int DEPTH = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [3:0]      req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic            fifo_we;
    logic [DW-1:0]   fifo_din;
    logic            fifo_re;
    logic [DW-1:0]   fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_clr;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [9:0]      level;
    logic [1:0]      last_gnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] sb[$];

    fifo_wr_arb_4x60 #(.DW(DW), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_re(fifo_re),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_clr(fifo_clr), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .level(level), .last_gnt(last_gnt)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: combinational flags, read data one cycle after fifo_re.
    logic [DW-1:0] mem [DEPTH];
    int wp, rp, cnt;
    assign fifo_full  = (cnt == DEPTH);
    assign fifo_empty = (cnt == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= 0; rp <= 0; cnt <= 0;
        end else if (fifo_clr) begin
            wp <= 0; rp <= 0; cnt <= 0;
        end else begin
            if (fifo_we && cnt < DEPTH) begin
                mem[wp] <= fifo_din;
                wp <= (wp + 1) % DEPTH;
            end
            if (fifo_re && cnt > 0) begin
                fifo_dout <= mem[rp];
                rp <= (rp + 1) % DEPTH;
            end
            cnt <= cnt + ((fifo_we && cnt < DEPTH) ? 1 : 0) - ((fifo_re && cnt > 0) ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_out", 64'(out_data), 64'hdead);
            else                check("out_data", 64'(out_data), 64'(sb.pop_front()));
        end
    end

    task automatic set_word(input int i, input logic [DW-1:0] w);
        req_data[i*DW +: DW] = w;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hf;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_fifo_we", 64'(fifo_we), 64'd0);
        check("rst_fifo_re", 64'(fifo_re), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_last_gnt", 64'(last_gnt), 64'd0);
        next_cycle();
        req_valid = '0;
        rst = 1'b0;
        next_cycle();

        // All four requesting: strict 0,1,2,3 rotation at one word per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) set_word(i, DW'(32'h100 * k + i));
            req_valid = 4'hf;
            @(negedge clk);
            check("rr_grant", 64'(req_ready), 64'(4'b1 << (k % 4)));
            check("rr_din", 64'(fifo_din), 64'(32'h100 * k + (k % 4)));
            sb.push_back(DW'(32'h100 * k + (k % 4)));
            check("rr_level_bound", 64'(level <= 10'd3), 64'd1);
            next_cycle();
        end
        req_valid = '0;
        drain(20);
        check("rr_last_gnt", 64'(last_gnt), 64'd3);

        // Single word from requester 2: out_valid exactly three cycles after fifo_we.
        out_ready = 1'b0;
        set_word(2, DW'(32'h123));
        req_valid = 4'b0100;
        @(negedge clk);
        check("lat_grant", 64'(req_ready), 64'b0100);
        check("lat_we", 64'(fifo_we), 64'd1);
        check("lat_din", 64'(fifo_din), 64'h123);
        sb.push_back(DW'(32'h123));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("lat_t1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_t2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_t3_valid", 64'(out_valid), 64'd1);
        check("lat_t3_data", 64'(out_data), 64'h123);
        check("lat_last_gnt", 64'(last_gnt), 64'd2);
        next_cycle();
        out_ready = 1'b1;
        drain(10);

        // Fill to capacity with no consumer, then drain back-to-back.
        next_cycle();
        out_ready = 1'b0;
        for (int n = 0; n < 520; n++) begin
            set_word(1, DW'(32'h1000 + n));
            req_valid = 4'b0010;
            @(negedge clk);
            if (n < 514) begin
                check("fill_accept", 64'(req_ready), 64'b0010);
                sb.push_back(DW'(32'h1000 + n));
            end else begin
                check("fill_refuse", 64'(req_ready), 64'd0);
            end
            next_cycle();
        end
        req_valid = 4'hf;
        @(negedge clk);
        check("full_level", 64'(level), 64'd514);
        check("full_no_grant", 64'(req_ready), 64'd0);
        next_cycle();
        req_valid = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 514; n++) begin
            @(negedge clk);
            check("drain_no_gap", 64'(out_valid), 64'd1);
            next_cycle();
        end
        @(negedge clk);
        check("drained_valid", 64'(out_valid), 64'd0);
        check("drained_level", 64'(level), 64'd0);
        check("drained_sb", 64'(sb.size()), 64'd0);
        next_cycle();

        // Continuous stream with out_ready toggling every cycle.
        for (int n = 0; n < 40; n++) begin
            set_word(3, DW'(32'h2000 + n));
            req_valid = 4'b1000;
            out_ready = n[0];
            @(negedge clk);
            check("tog_grant", 64'(req_ready), 64'b1000);
            sb.push_back(DW'(32'h2000 + n));
            next_cycle();
        end
        req_valid = '0;
        out_ready = 1'b1;
        drain(40);

        // Synchronous clear with five words held.
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            set_word(0, DW'(32'h3000 + n));
            req_valid = 4'b0001;
            @(negedge clk);
            check("clr_fill_grant", 64'(req_ready), 64'b0001);
            sb.push_back(DW'(32'h3000 + n));
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        check("clr_pre_level", 64'(level), 64'd5);
        next_cycle();
        clr = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        check("clr_no_grant", 64'(req_ready), 64'd0);
        check("clr_no_we", 64'(fifo_we), 64'd0);
        check("clr_no_re", 64'(fifo_re), 64'd0);
        check("clr_passthru", 64'(fifo_clr), 64'd1);
        next_cycle();
        clr = 1'b0;
        req_valid = '0;
        sb.delete();
        @(negedge clk);
        check("clr_level", 64'(level), 64'd0);
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_fifo_clr_low", 64'(fifo_clr), 64'd0);
        check("clr_last_gnt", 64'(last_gnt), 64'd0);
        next_cycle();

        // Reset while a read is in flight and the buffer holds a word.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) set_word(i, DW'(32'h4000 + 16 * n + i));
            req_valid = 4'hf;
            @(negedge clk);
            check("rstmid_grant", 64'(req_ready), 64'(4'b1 << n));
            if (n < 3) begin
                sb.push_back(DW'(32'h4000 + 16 * n + n));
                next_cycle();
            end
        end
        check("rstmid_e1", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_level", 64'(level), 64'd0);
        check("rstmid_req_ready", 64'(req_ready), 64'd0);
        check("rstmid_fifo_re", 64'(fifo_re), 64'd0);
        sb.delete();
        req_valid = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        set_word(2, DW'(32'habc));
        req_valid = 4'b0100;
        @(negedge clk);
        check("post_rst_grant", 64'(req_ready), 64'b0100);
        sb.push_back(DW'(32'habc));
        next_cycle();
        req_valid = '0;
        out_ready = 1'b1;
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
